// File: rtl/acc_drain_writer.sv
// ---------------------------------------------------------------------------
// acc_drain_writer
//
// Consumer end of the accumulator array's output stream. Each cycle the
// array raises acc_valid_i, one row of SIZE columns is captured, tagged with
// its output-buffer address and pushed into a small show-ahead FIFO. The
// array cannot be stalled, so the FIFO absorbs write back-pressure. Rows
// leave the FIFO as valid/ready write requests. Once the array's end-of-tile
// pulse has been seen and the FIFO has drained, a one-cycle tile_done_o is
// produced.
//
// Ports:
//   clk, rst        clock (rising edge) and asynchronous active-high reset
//   start_i         arms a new tile; sampled only in IDLE
//   base_addr_i     address of row 0, latched on an accepted start_i
//   row_stride_i    address increment per row, latched on an accepted start_i
//   acc_valid_i     row strobe from the array (no back-pressure possible)
//   acc_data_i      row data, column i at [i*DATA_WIDTH +: DATA_WIDTH]
//   tile_over_i     end-of-tile pulse from the array
//   wr_valid_o      write request valid (FIFO not empty)
//   wr_ready_i      output buffer accepts the request
//   wr_addr_o       write address
//   wr_data_o       write data, same packing as acc_data_i
//   busy_o          high whenever the FSM is not IDLE
//   tile_done_o     one-cycle completion pulse
//   err_o           sticky error flag (dropped rows)
//
// Handshake: a write transfers on every rising edge where wr_valid_o and
// wr_ready_i are both high. Once wr_valid_o is raised it stays high, with
// wr_addr_o/wr_data_o unchanged, until that transfer happens; wr_valid_o
// never depends combinationally on wr_ready_i.
// ---------------------------------------------------------------------------
module acc_drain_writer #(
  parameter int SIZE       = 16,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start_i,
  input  logic [ADDR_WIDTH-1:0]        base_addr_i,
  input  logic [ADDR_WIDTH-1:0]        row_stride_i,
  input  logic                         acc_valid_i,
  input  logic [SIZE*DATA_WIDTH-1:0]   acc_data_i,
  input  logic                         tile_over_i,
  output logic                         wr_valid_o,
  input  logic                         wr_ready_i,
  output logic [ADDR_WIDTH-1:0]        wr_addr_o,
  output logic [SIZE*DATA_WIDTH-1:0]   wr_data_o,
  output logic                         busy_o,
  output logic                         tile_done_o,
  output logic                         err_o
);

  localparam int DW_ROW = SIZE * DATA_WIDTH;
  localparam int EW     = ADDR_WIDTH + DW_ROW;
  localparam int PW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW     = $clog2(FIFO_DEPTH + 1);
  localparam int RW     = $clog2(SIZE + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;      // address of the next row
  logic [ADDR_WIDTH-1:0] stride_q, stride_d;
  logic [RW-1:0]         row_cnt_q, row_cnt_d;
  logic                  err_q, err_d;
  logic                  done_q, done_d;

  logic [EW-1:0]         mem_q [FIFO_DEPTH];
  logic [EW-1:0]         mem_d [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;

  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  pop;
  logic                  push;
  logic [PW-1:0]         rd_idx;

  always_comb begin
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == CW'(FIFO_DEPTH));
    pop        = !fifo_empty && wr_ready_i;

    state_d   = state_q;
    addr_d    = addr_q;
    stride_d  = stride_q;
    row_cnt_d = row_cnt_q;
    err_d     = err_q;
    done_d    = 1'b0;
    push      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d   = ST_DRAIN;
          addr_d    = base_addr_i;
          stride_d  = row_stride_i;
          row_cnt_d = '0;
          err_d     = 1'b0;
        end
        // A stray row in IDLE is an error even if start_i clears err this cycle.
        if (acc_valid_i) err_d = 1'b1;
      end
      ST_DRAIN: begin
        if (acc_valid_i) begin
          if (row_cnt_q == RW'(SIZE)) begin
            err_d = 1'b1;
          end else begin
            // The row slot is consumed even when the FIFO drops it, so
            // addresses of later rows stay aligned with their row index.
            row_cnt_d = row_cnt_q + RW'(1);
            addr_d    = addr_q + stride_q;
            if (!fifo_full || pop) push = 1'b1;
            else                   err_d = 1'b1;
          end
        end
        if (tile_over_i) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (acc_valid_i) err_d = 1'b1;
        if (fifo_empty) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = {addr_q, acc_data_i};

    // Pointers wrap naturally since FIFO_DEPTH is a power of two.
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);

    // When empty, present the most recently popped entry so the outputs
    // hold their last value instead of showing an unrelated stale slot.
    rd_idx = fifo_empty ? (rd_ptr_q - PW'(1)) : rd_ptr_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      stride_q  <= '0;
      row_cnt_q <= '0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      stride_q  <= stride_d;
      row_cnt_q <= row_cnt_d;
      err_q     <= err_d;
      done_q    <= done_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

  assign wr_valid_o             = !fifo_empty;
  assign {wr_addr_o, wr_data_o} = mem_q[rd_idx];
  assign busy_o                 = (state_q != ST_IDLE);
  assign tile_done_o            = done_q;
  assign err_o                  = err_q;

endmodule

// File: doc/acc_drain_writer.md
Name: acc_drain_writer

Overview:
- Consumer end of the accumulator array's output stream.
- Captures one accumulated row (SIZE columns) per cycle when the array asserts its row-valid strobe, and tags each row with its output address.
- Buffers rows in a small FIFO, because the array cannot be stalled, and emits them as valid/ready write requests to the output buffer.
- Signals completion of a tile once the array's end-of-tile pulse has arrived and the buffer has fully drained.

Parameters:
- SIZE, 16, number of columns per row and rows per tile.
- DATA_WIDTH, 32, signed accumulator width per column.
- ADDR_WIDTH, 16, output buffer address width.
- FIFO_DEPTH, 4, row buffer entries; power of two, at least 2.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start_i  in  1  one-cycle pulse; arms the block for a new tile; sampled only in IDLE.
- base_addr_i  in  ADDR_WIDTH  address of row 0; latched on an accepted start_i.
- row_stride_i  in  ADDR_WIDTH  address increment per row; latched on an accepted start_i.
- acc_valid_i  in  1  row-valid strobe from the accumulator array; one row per high cycle; cannot be back-pressured.
- acc_data_i  in  SIZE*DATA_WIDTH  row data; column i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- tile_over_i  in  1  one-cycle end-of-tile pulse from the accumulator array.
- wr_valid_o  out  1  write request valid.
- wr_ready_i  in  1  output buffer accepts the request.
- wr_addr_o  out  ADDR_WIDTH  write address.
- wr_data_o  out  SIZE*DATA_WIDTH  write data; same packing as acc_data_i.
- busy_o  out  1  high in any state other than IDLE.
- tile_done_o  out  1  one-cycle completion pulse.
- err_o  out  1  sticky error flag.

Behaviour:
- Reset values: all outputs 0; FIFO empty; row counter 0; state IDLE; err_o cleared. Reset mid-tile discards all buffered rows and no tile_done_o is produced.
- States:
  - IDLE: start_i -> DRAIN. Latch base_addr_i and row_stride_i, clear the row counter.
  - DRAIN: capture rows. tile_over_i -> FLUSH.
  - FLUSH: no further captures. When the FIFO is empty -> IDLE and pulse tile_done_o for one cycle.
  - If the FIFO is already empty when tile_over_i arrives, FLUSH lasts one cycle. tile_done_o asserts on the cycle after the FLUSH empty check.
- Capture (DRAIN only): on acc_valid_i, push {addr, acc_data_i} into the FIFO and increment the row counter.
  - addr = base + row_cnt*row_stride, truncated to ADDR_WIDTH; wrap-around is silent.
  - Implement the address with a running-sum register, not a multiplier.
- acc_valid_i and tile_over_i in the same cycle: the row is captured, then the block enters FLUSH.
- Rows beyond SIZE in one tile (row_cnt == SIZE): row dropped, err_o set.
- acc_valid_i in IDLE or FLUSH: row dropped, err_o set.
- FIFO full when acc_valid_i arrives:
  - Accepted if a pop occurs in the same cycle (wr_valid_o && wr_ready_i); occupancy unchanged.
  - Otherwise the row is dropped, err_o set, and the row counter still increments, so later addresses stay correct.
- Output: show-ahead FIFO; wr_valid_o = FIFO not empty.
  - A row captured into an empty FIFO appears on wr_valid_o, wr_addr_o and wr_data_o on the next cycle (latency 1).
  - While wr_valid_o && !wr_ready_i, wr_addr_o and wr_data_o are held stable.
  - When the FIFO is empty, wr_data_o and wr_addr_o hold their last value; they are don't-care while wr_valid_o is low.
- start_i outside IDLE: ignored. tile_over_i outside DRAIN: ignored.
- err_o: sticky; cleared only by reset or by an accepted start_i.
- Throughput: one row per cycle sustained while wr_ready_i is held high.

Test Plan:
- Basic tile: SIZE=4, base=0x100, stride=0x10, wr_ready_i=1. start, four back-to-back acc_valid_i rows with column j of row r = r*10+j, then tile_over_i -> four writes at 0x100, 0x110, 0x120, 0x130 with matching data, each one cycle after capture; a single tile_done_o; err_o=0.
- Back-pressure: wr_ready_i=0 for the whole capture of 4 rows (FIFO_DEPTH=4), then released -> no loss, writes in order, wr_data_o stable while stalled, tile_done_o one cycle after the FLUSH empty check that follows the 4th accepted write.
- Overflow: FIFO_DEPTH=4, wr_ready_i=0, 5 rows -> rows 0-3 written to the correct addresses, row 4 dropped, err_o=1; the next start_i clears err_o.
- Full with simultaneous pop: FIFO full, wr_ready_i=1 in the same cycle as acc_valid_i -> row accepted, err_o stays 0.
- Boundaries: tile_over_i coincident with the last acc_valid_i -> row captured and written; 5th row on SIZE=4 -> err_o=1; acc_valid_i in IDLE -> no write, err_o=1; base=0xFFF0, stride=0x10 -> second row address wraps to 0x0000.
- Reset mid-tile: assert rst with 2 rows buffered -> wr_valid_o=0, busy_o=0 immediately; no tile_done_o; a subsequent tile completes normally.
